mult_add_ctrl: RTL and testbench

MULT_ADD_CTRL -- requirements
Module: mult_add_ctrl

---
 rtl/mult_add_ctrl.sv | 132 +++++++++++++
 tb/tb_mult_add_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_add_ctrl.sv
// Control unit for a shift-free repeated-addition multiplier.
// It loads A and B from a shared bus, clears P, then adds A into P and
// decrements B until the datapath reports B == 0. It also keeps a sticky
// overflow flag and counts add iterations.
//
// Bus handshake: a word moves across the bus in a cycle where in_valid and
// in_ready are both high at the rising edge. in_ready is high only in
// LOAD_A/LOAD_B, and is dropped when abort is high. The data is captured by
// the datapath through ld_a/ld_b in that same cycle.
module mult_add_ctrl #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eqz,
  input  logic             add_carry,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             dec_b,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [WIDTH-1:0] iter_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    ADD    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept_start;

  assign accept_start = (state == IDLE) && start;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  // State register; reset abandons any operation in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; abort outside IDLE overrides everything.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    clr_p     = 1'b0;
    ld_p      = 1'b0;
    dec_b     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_a      = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_b      = 1'b1;
          clr_p     = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        state_nxt = eqz ? DONE : ADD;
      end
      ADD: begin
        ld_p      = 1'b1;
        dec_b     = 1'b1;
        state_nxt = CHECK;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      in_ready  = 1'b0;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      clr_p     = 1'b0;
      ld_p      = 1'b0;
      dec_b     = 1'b0;
      done      = 1'b0;
      state_nxt = IDLE;
    end
  end

  // Iteration counter and sticky overflow, both cleared by an accepted start.
  // The counter tracks cycles spent in ADD, including an aborted ADD cycle.
  // Overflow follows the actual (possibly suppressed) ld_p strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt <= '0;
      ovf      <= 1'b0;
    end else if (accept_start) begin
      iter_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (state == ADD) iter_cnt <= iter_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
      if (ld_p && add_carry) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_add_ctrl.sv
// Bench for mult_add_ctrl. A small behavioural datapath answers eqz and
// add_carry. The driver pushes the expected completion (iteration count,
// overflow, done cycle) when it issues a start. A monitor pops and compares
// the expectation on every done pulse.
module tb_mult_add_ctrl;
  localparam int W = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic start, abort, in_valid, in_ready, eqz, add_carry;
  logic ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, ovf;
  logic [W-1:0] iter_cnt;
  logic [2:0]   state_dbg;

  mult_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .eqz(eqz), .add_carry(add_carry),
    .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .ld_p(ld_p), .dec_b(dec_b),
    .busy(busy), .done(done), .ovf(ovf), .iter_cnt(iter_cnt), .state_dbg(state_dbg)
  );

  // behavioural datapath
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] a_reg, b_reg, p_reg;
  logic [W:0]   sum;
  int           ldp_seen;
  logic         carry_arm = 1'b0;

  assign sum       = {1'b0, a_reg} + {1'b0, p_reg};
  assign eqz       = (b_reg == '0);
  assign add_carry = sum[W] | (carry_arm && (ldp_seen == 1));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0; b_reg <= '0; p_reg <= '0; ldp_seen <= 0;
    end else begin
      if (ld_a) a_reg <= op_a;
      if (ld_b) b_reg <= op_b;
      if (clr_p) begin p_reg <= '0; ldp_seen <= 0; end
      if (ld_p) begin p_reg <= sum[W-1:0]; ldp_seen <= ldp_seen + 1; end
      if (dec_b) b_reg <= b_reg - 1'b1;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      if (ld_a | ld_b | clr_p | ld_p | dec_b | done) begin
        check("strobe_groups", int'(ld_a) + int'(ld_b | clr_p) + int'(ld_p | dec_b) + int'(done), 1);
        check("ldb_clrp_pair", ld_b, clr_p);
        check("ldp_decb_pair", ld_p, dec_b);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_iter_cnt", iter_cnt, exp_q[0]);
          check("done_ldp_count", ldp_seen, exp_q[0]);
          check("done_ovf", ovf, exp_ovf_q[0]);
          check("done_cycle", cyc, exp_cyc_q[0]);
          void'(exp_q.pop_front());
          void'(exp_ovf_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
  end

  // driver tasks (called #1 after a rising edge, in IDLE)
  task automatic start_op(input int a, input int b, input int stall, input int exp_iter,
                          input logic exp_ovf, input bit push, output int s);
    op_a = W'(a);
    op_b = W'(b);
    start = 1'b1;
    in_valid = (stall == 0);
    s = cyc;
    if (push) begin
      exp_q.push_back(W'(exp_iter));
      exp_ovf_q.push_back(exp_ovf);
      exp_cyc_q.push_back(s + 4 + 2 * b + stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (stall > 0) begin
      check("stall_in_ready", in_ready, 1);
      check("stall_no_ld_a", ld_a, 0);
      repeat (stall) @(posedge clk);
      #1 in_valid = 1'b1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete(); exp_ovf_q.delete(); exp_cyc_q.delete();
    end
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl_outs"}, {busy, done, in_ready, ld_a, ld_b, clr_p, ld_p, dec_b, ovf}, 0);
    check({tag, "_iter_cnt"}, iter_cnt, 0);
  endtask

  initial begin
    int s;
    int k;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_state", state_dbg, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // A=5, B=3: done at +10, three adds
    start_op(5, 3, 0, 3, 1'b0, 1'b1, s);
    wait_drain(60);
    check("hold_iter_cnt", iter_cnt, 3);
    check("hold_busy", busy, 0);

    // B=0: no adds, done at +4
    start_op(9, 0, 0, 0, 1'b0, 1'b1, s);
    wait_drain(60);

    // carry on the second add sets ovf; loop still runs to the end
    carry_arm = 1'b1;
    start_op(5, 3, 0, 3, 1'b1, 1'b1, s);
    wait_drain(60);
    carry_arm = 1'b0;
    check("ovf_sticky_after_done", ovf, 1);
    start_op(5, 1, 0, 1, 1'b0, 1'b1, s);
    check("ovf_cleared_on_start", ovf, 0);
    check("iter_cleared_on_start", iter_cnt, 0);
    wait_drain(60);

    // in_valid low 3 cycles in LOAD_A, start pulsed during ADD
    start_op(7, 2, 3, 2, 1'b0, 1'b1, s);
    k = 0;
    while (!ld_p && k < 40) begin @(negedge clk); k++; end
    check("found_add_cycle", ld_p, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(60);
    repeat (3) @(posedge clk);
    #1 check("start_not_queued", busy, 0);

    // abort during the second ADD (cycle +6)
    start_op(5, 4, 0, 0, 1'b0, 1'b0, s);
    repeat (5) @(posedge clk);
    #1 check("abort_at_cycle6", cyc - s, 6);
    abort = 1'b1;
    #2;
    check("abort_suppress", {ld_p, dec_b, done, in_ready}, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_iter_cnt", iter_cnt, 2);
    repeat (12) @(posedge clk);
    #1 check("abort_stays_idle", busy, 0);

    // abort in IDLE is ignored
    abort = 1'b1;
    start_op(3, 1, 0, 1, 1'b0, 1'b1, s);
    abort = 1'b0;
    check("idle_abort_ignored", busy, 1);
    wait_drain(60);

    // reset during ADD
    start_op(5, 3, 0, 0, 1'b0, 1'b0, s);
    repeat (3) @(posedge clk);
    #2 check("first_add_cycle4", ld_p, 1);
    rst = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_op(5, 3, 0, 3, 1'b0, 1'b1, s);
    wait_drain(60);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
